// File: rtl/sy_pkg.sv
// rtl/sy_pkg.sv - shared types and constants for the EXU issue queue slice
package sy_pkg;

    localparam int PHY_REG_WTH  = 6;
    localparam int EXU_IQ_DEPTH = 4;

    // Micro-op as handed from dispatch to the execution unit. The rsN_state
    // bits mean "source operand value is available".
    typedef struct packed {
        logic [7:0]             tag;
        logic [3:0]             op;
        logic [PHY_REG_WTH-1:0] rd_idx;
        logic                   rd_is_fp;
        logic [PHY_REG_WTH-1:0] rs1_idx;
        logic                   rs1_is_fp;
        logic                   rs1_state;
        logic [PHY_REG_WTH-1:0] rs2_idx;
        logic                   rs2_is_fp;
        logic                   rs2_state;
        logic [PHY_REG_WTH-1:0] rs3_idx;
        logic                   rs3_state;
    } exu_packet_t;

    typedef struct packed {
        logic        valid;
        exu_packet_t pkt;
    } exu_iq_entry_t;

    // All writeback update buses bundled, so wakeup comparators take one port.
    typedef struct packed {
        logic                   alu_en;
        logic [PHY_REG_WTH-1:0] alu_idx;
        logic                   csr_en;
        logic [PHY_REG_WTH-1:0] csr_idx;
        logic                   mdu_en;
        logic [PHY_REG_WTH-1:0] mdu_idx;
        logic                   lsu_en;
        logic                   lsu_is_fp;
        logic [PHY_REG_WTH-1:0] lsu_idx;
        logic                   fpu_en;
        logic                   fpu_is_fp;
        logic [PHY_REG_WTH-1:0] fpu_idx;
    } upd_bus_t;

endpackage

// File: rtl/sy_ppl_iq_wakeup.sv
// rtl/sy_ppl_iq_wakeup.sv - operand wakeup match against the writeback buses
// Ports: idx_i/is_fp_i operand physical index and register file,
//        upd_i bundled update buses, match_o operand produced this cycle.
module sy_ppl_iq_wakeup
    import sy_pkg::*;
(
    input  logic [PHY_REG_WTH-1:0] idx_i,
    input  logic                   is_fp_i,
    input  upd_bus_t               upd_i,
    output logic                   match_o
);

    logic int_hit;
    logic mix_hit;

    // ALU/CSR/MDU only ever write the integer file.
    assign int_hit = !is_fp_i &&
                     ((upd_i.alu_en && (idx_i == upd_i.alu_idx)) ||
                      (upd_i.csr_en && (idx_i == upd_i.csr_idx)) ||
                      (upd_i.mdu_en && (idx_i == upd_i.mdu_idx)));

    // LSU/FPU can target either file, so the file flag must agree.
    assign mix_hit = (upd_i.lsu_en && (idx_i == upd_i.lsu_idx) && (is_fp_i == upd_i.lsu_is_fp)) ||
                     (upd_i.fpu_en && (idx_i == upd_i.fpu_idx) && (is_fp_i == upd_i.fpu_is_fp));

    assign match_o = int_hit || mix_hit;

endmodule

// File: rtl/sy_ppl_exu_iq.sv
// rtl/sy_ppl_exu_iq.sv - in-order issue queue between dispatch and an EXU
// Ports: clk_i/rst_i clock and async active-low reset, flush_i discard all;
//        dis_iq__* dispatch handshake in, iq_exu__*/exu_iq__* issue handshake
//        out, *_update_* writeback wakeup buses, iq_cnt_o occupancy.
module sy_ppl_exu_iq
    import sy_pkg::*;
#(
    parameter int DEPTH   = EXU_IQ_DEPTH,
    parameter int PTR_WTH = $clog2(DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   dis_iq__vld_i,
    output logic                   iq_dis__rdy_o,
    input  exu_packet_t            dis_iq__packet_i,
    output logic                   iq_exu__vld_o,
    input  logic                   exu_iq__rdy_i,
    output exu_packet_t            iq_exu__packet_o,
    input  logic                   alu_update_en_i,
    input  logic [PHY_REG_WTH-1:0] alu_update_idx_i,
    input  logic                   csr_update_en_i,
    input  logic [PHY_REG_WTH-1:0] csr_update_idx_i,
    input  logic                   mdu_update_en_i,
    input  logic [PHY_REG_WTH-1:0] mdu_update_idx_i,
    input  logic                   lsu_update_en_i,
    input  logic                   lsu_update_is_fp_i,
    input  logic [PHY_REG_WTH-1:0] lsu_update_idx_i,
    input  logic                   fpu_update_en_i,
    input  logic                   fpu_update_is_fp_i,
    input  logic [PHY_REG_WTH-1:0] fpu_update_idx_i,
    output logic [PTR_WTH:0]       iq_cnt_o
);

    localparam logic [PTR_WTH:0] PTR_ONE = 1;

    exu_iq_entry_t    mem [DEPTH];
    logic [PTR_WTH:0] wp;
    logic [PTR_WTH:0] rp;
    upd_bus_t         upd;
    logic [DEPTH-1:0] res_m1;
    logic [DEPTH-1:0] res_m2;
    logic [DEPTH-1:0] res_m3;
    logic             in_m1;
    logic             in_m2;
    logic             in_m3;
    logic             full;
    logic             enq;
    logic             deq;
    exu_iq_entry_t    head;
    exu_packet_t      wr_pkt;

    always_comb begin
        upd           = '0;
        upd.alu_en    = alu_update_en_i;
        upd.alu_idx   = alu_update_idx_i;
        upd.csr_en    = csr_update_en_i;
        upd.csr_idx   = csr_update_idx_i;
        upd.mdu_en    = mdu_update_en_i;
        upd.mdu_idx   = mdu_update_idx_i;
        upd.lsu_en    = lsu_update_en_i;
        upd.lsu_is_fp = lsu_update_is_fp_i;
        upd.lsu_idx   = lsu_update_idx_i;
        upd.fpu_en    = fpu_update_en_i;
        upd.fpu_is_fp = fpu_update_is_fp_i;
        upd.fpu_idx   = fpu_update_idx_i;
    end

    // Wakeup comparators for every resident operand; rs3 is always an FP source.
    for (genvar i = 0; i < DEPTH; i++) begin : g_res
        sy_ppl_iq_wakeup u_wk_rs1 (.idx_i(mem[i].pkt.rs1_idx), .is_fp_i(mem[i].pkt.rs1_is_fp),
                                   .upd_i(upd), .match_o(res_m1[i]));
        sy_ppl_iq_wakeup u_wk_rs2 (.idx_i(mem[i].pkt.rs2_idx), .is_fp_i(mem[i].pkt.rs2_is_fp),
                                   .upd_i(upd), .match_o(res_m2[i]));
        sy_ppl_iq_wakeup u_wk_rs3 (.idx_i(mem[i].pkt.rs3_idx), .is_fp_i(1'b1),
                                   .upd_i(upd), .match_o(res_m3[i]));
    end

    // Incoming packet comparators: a producer writing back in the same cycle
    // the consumer is enqueued would otherwise be missed forever.
    sy_ppl_iq_wakeup u_wk_in1 (.idx_i(dis_iq__packet_i.rs1_idx), .is_fp_i(dis_iq__packet_i.rs1_is_fp),
                               .upd_i(upd), .match_o(in_m1));
    sy_ppl_iq_wakeup u_wk_in2 (.idx_i(dis_iq__packet_i.rs2_idx), .is_fp_i(dis_iq__packet_i.rs2_is_fp),
                               .upd_i(upd), .match_o(in_m2));
    sy_ppl_iq_wakeup u_wk_in3 (.idx_i(dis_iq__packet_i.rs3_idx), .is_fp_i(1'b1),
                               .upd_i(upd), .match_o(in_m3));

    assign full          = (wp[PTR_WTH-1:0] == rp[PTR_WTH-1:0]) && (wp[PTR_WTH] != rp[PTR_WTH]);
    assign iq_dis__rdy_o = !full;
    assign iq_cnt_o      = wp - rp;

    assign head          = mem[rp[PTR_WTH-1:0]];
    // Readiness uses registered state only: no same-cycle wakeup or enqueue bypass.
    assign iq_exu__vld_o = head.valid && head.pkt.rs1_state && head.pkt.rs2_state &&
                           head.pkt.rs3_state && !flush_i;

    assign enq = dis_iq__vld_i && iq_dis__rdy_o && !flush_i;
    assign deq = iq_exu__vld_o && exu_iq__rdy_i;

    always_comb begin
        wr_pkt           = dis_iq__packet_i;
        wr_pkt.rs1_state = dis_iq__packet_i.rs1_state | in_m1;
        wr_pkt.rs2_state = dis_iq__packet_i.rs2_state | in_m2;
        wr_pkt.rs3_state = dis_iq__packet_i.rs3_state | in_m3;
    end

    // State bits read as 1 whenever the head is live; tying them to valid keeps
    // the output all-zero out of reset while storage is zero.
    always_comb begin
        iq_exu__packet_o           = head.pkt;
        iq_exu__packet_o.rs1_state = head.valid;
        iq_exu__packet_o.rs2_state = head.valid;
        iq_exu__packet_o.rs3_state = head.valid;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wp <= '0;
            rp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush_i) begin
            wp <= '0;
            rp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i].valid <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem[i].valid) begin
                    mem[i].pkt.rs1_state <= mem[i].pkt.rs1_state | res_m1[i];
                    mem[i].pkt.rs2_state <= mem[i].pkt.rs2_state | res_m2[i];
                    mem[i].pkt.rs3_state <= mem[i].pkt.rs3_state | res_m3[i];
                end
            end
            if (deq) begin
                mem[rp[PTR_WTH-1:0]].valid <= 1'b0;
                rp <= rp + PTR_ONE;
            end
            // The write slot is never the dequeue slot: enq requires not-full.
            if (enq) begin
                mem[wp[PTR_WTH-1:0]].valid <= 1'b1;
                mem[wp[PTR_WTH-1:0]].pkt   <= wr_pkt;
                wp <= wp + PTR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_sy_ppl_exu_iq.sv
// tb/tb_sy_ppl_exu_iq.sv - scoreboard bench for sy_ppl_exu_iq
module tb_sy_ppl_exu_iq;
    import sy_pkg::*;

    localparam int DEPTH   = 4;
    localparam int PTR_WTH = 2;

    logic                   clk = 1'b0;
    logic                   rst_i;
    logic                   flush_i;
    logic                   dis_iq__vld_i;
    logic                   iq_dis__rdy_o;
    exu_packet_t            dis_iq__packet_i;
    logic                   iq_exu__vld_o;
    logic                   exu_iq__rdy_i;
    exu_packet_t            iq_exu__packet_o;
    logic                   alu_update_en_i, csr_update_en_i, mdu_update_en_i;
    logic [PHY_REG_WTH-1:0] alu_update_idx_i, csr_update_idx_i, mdu_update_idx_i;
    logic                   lsu_update_en_i, fpu_update_en_i;
    logic                   lsu_update_is_fp_i, fpu_update_is_fp_i;
    logic [PHY_REG_WTH-1:0] lsu_update_idx_i, fpu_update_idx_i;
    logic [PTR_WTH:0]       iq_cnt_o;

    int passed = 0;
    int total  = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    sy_ppl_exu_iq #(.DEPTH(DEPTH), .PTR_WTH(PTR_WTH)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .dis_iq__vld_i(dis_iq__vld_i), .iq_dis__rdy_o(iq_dis__rdy_o),
        .dis_iq__packet_i(dis_iq__packet_i),
        .iq_exu__vld_o(iq_exu__vld_o), .exu_iq__rdy_i(exu_iq__rdy_i),
        .iq_exu__packet_o(iq_exu__packet_o),
        .alu_update_en_i(alu_update_en_i), .alu_update_idx_i(alu_update_idx_i),
        .csr_update_en_i(csr_update_en_i), .csr_update_idx_i(csr_update_idx_i),
        .mdu_update_en_i(mdu_update_en_i), .mdu_update_idx_i(mdu_update_idx_i),
        .lsu_update_en_i(lsu_update_en_i), .lsu_update_is_fp_i(lsu_update_is_fp_i),
        .lsu_update_idx_i(lsu_update_idx_i),
        .fpu_update_en_i(fpu_update_en_i), .fpu_update_is_fp_i(fpu_update_is_fp_i),
        .fpu_update_idx_i(fpu_update_idx_i),
        .iq_cnt_o(iq_cnt_o)
    );

    function automatic exu_packet_t mk(input logic [7:0] tag,
                                       input logic [5:0] i1, input logic f1, input logic s1,
                                       input logic [5:0] i2, input logic f2, input logic s2,
                                       input logic [5:0] i3, input logic s3);
        exu_packet_t p;
        p = '0;
        p.tag = tag; p.op = tag[3:0]; p.rd_idx = tag[5:0] ^ 6'h2a;
        p.rs1_idx = i1; p.rs1_is_fp = f1; p.rs1_state = s1;
        p.rs2_idx = i2; p.rs2_is_fp = f2; p.rs2_state = s2;
        p.rs3_idx = i3; p.rs3_state = s3;
        return p;
    endfunction

    task automatic clear_inputs();
        flush_i = 0; dis_iq__vld_i = 0; dis_iq__packet_i = '0;
        alu_update_en_i = 0; alu_update_idx_i = '0;
        csr_update_en_i = 0; csr_update_idx_i = '0;
        mdu_update_en_i = 0; mdu_update_idx_i = '0;
        lsu_update_en_i = 0; lsu_update_is_fp_i = 0; lsu_update_idx_i = '0;
        fpu_update_en_i = 0; fpu_update_is_fp_i = 0; fpu_update_idx_i = '0;
    endtask

    // Inputs are set at a falling edge; outputs are sampled 1ns later and the
    // task returns at the next falling edge (one rising edge consumed).
    task automatic do_cycle(output logic vld, output logic iss, output logic [7:0] tag,
                            output logic [PTR_WTH:0] cnt, output logic rdy);
        #1;
        vld = iq_exu__vld_o;
        iss = iq_exu__vld_o && exu_iq__rdy_i;
        tag = iq_exu__packet_o.tag;
        cnt = iq_cnt_o;
        rdy = iq_dis__rdy_o;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        total++; if (iq_dis__rdy_o !== 1'b1) $display("FAIL reset_rdy: got %b expected 1", iq_dis__rdy_o); else passed++;
        total++; if (iq_exu__vld_o !== 1'b0) $display("FAIL reset_vld: got %b expected 0", iq_exu__vld_o); else passed++;
        total++; if (iq_cnt_o !== 3'd0) $display("FAIL reset_cnt: got %0d expected 0", iq_cnt_o); else passed++;
        total++; if (iq_exu__packet_o !== '0) $display("FAIL reset_packet: got %h expected 0", iq_exu__packet_o); else passed++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic vld, iss, rdy, prev_acc;
        logic [7:0] tag, e;
        logic [PTR_WTH:0] cnt;
        clear_inputs(); exu_iq__rdy_i = 1; prev_acc = 0;
        for (int c = 0; c < 6; c++) begin
            dis_iq__vld_i = (c < 4);
            dis_iq__packet_i = mk(8'(c + 1), 6'd1, 0, 1, 6'd2, 1, 1, 6'd3, 1);
            do_cycle(vld, iss, tag, cnt, rdy);
            total++; if (rdy !== 1'b1) $display("FAIL b2b_rdy: got %b expected 1", rdy); else passed++;
            total++; if (cnt > 1) $display("FAIL b2b_cnt: got %0d expected <=1", cnt); else passed++;
            total++; if (iss !== prev_acc) $display("FAIL b2b_latency: got %b expected %b", iss, prev_acc); else passed++;
            if (iss) begin
                total++;
                if (exp_q.size() == 0) $display("FAIL b2b_order: got tag %0d expected none", tag);
                else begin e = exp_q.pop_front(); if (tag !== e) $display("FAIL b2b_order: got tag %0d expected %0d", tag, e); else passed++; end
            end
            if (c < 4) exp_q.push_back(8'(c + 1));
            prev_acc = (c < 4);
        end
    endtask

    task automatic test_full();
        logic vld, iss, rdy;
        logic [7:0] tag, e;
        logic [PTR_WTH:0] cnt;
        int m_cnt;
        clear_inputs(); exu_iq__rdy_i = 0; m_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            dis_iq__vld_i = 1;
            dis_iq__packet_i = mk(8'(10 + c), 6'd4, 0, 1, 6'd5, 0, 1, 6'd6, 1);
            do_cycle(vld, iss, tag, cnt, rdy);
            total++; if (rdy !== (m_cnt < DEPTH)) $display("FAIL full_rdy: got %b expected %b", rdy, (m_cnt < DEPTH)); else passed++;
            total++; if (cnt !== 3'(m_cnt)) $display("FAIL full_cnt: got %0d expected %0d", cnt, m_cnt); else passed++;
            if (m_cnt < DEPTH) begin exp_q.push_back(8'(10 + c)); m_cnt++; end
        end
        dis_iq__vld_i = 0;
        for (int c = 0; c < 2; c++) begin
            do_cycle(vld, iss, tag, cnt, rdy);
            total++; if (cnt !== 3'd4) $display("FAIL full_cnt4: got %0d expected 4", cnt); else passed++;
            total++; if (rdy !== 1'b0) $display("FAIL full_rdy0: got %b expected 0", rdy); else passed++;
            total++; if (vld !== 1'b1 || tag !== 8'd10) $display("FAIL full_stall_head: got vld %b tag %0d expected vld 1 tag 10", vld, tag); else passed++;
        end
        exu_iq__rdy_i = 1;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            do_cycle(vld, iss, tag, cnt, rdy);
            if (iss) begin
                total++; e = exp_q.pop_front();
                if (tag !== e) $display("FAIL full_order: got tag %0d expected %0d", tag, e); else passed++;
            end
        end
        total++; if (exp_q.size() != 0) $display("FAIL full_drain: got %0d left expected 0", exp_q.size()); else passed++;
        do_cycle(vld, iss, tag, cnt, rdy);
        total++; if (cnt !== 3'd0 || vld !== 1'b0) $display("FAIL full_empty: got cnt %0d vld %b expected 0 0", cnt, vld); else passed++;
    endtask

    task automatic test_wakeup();
        logic vld, iss, rdy;
        logic [7:0] tag;
        logic [PTR_WTH:0] cnt;
        clear_inputs(); exu_iq__rdy_i = 1;
        dis_iq__vld_i = 1;
        dis_iq__packet_i = mk(8'd20, 6'd7, 0, 0, 6'd3, 1, 1, 6'd9, 1);
        exp_q.push_back(8'd20);
        do_cycle(vld, iss, tag, cnt, rdy);
        clear_inputs();
        fpu_update_en_i = 1; fpu_update_is_fp_i = 1; fpu_update_idx_i = 6'd7;
        lsu_update_en_i = 1; lsu_update_is_fp_i = 1; lsu_update_idx_i = 6'd7;
        do_cycle(vld, iss, tag, cnt, rdy);
        total++; if (vld !== 1'b0) $display("FAIL wk_fp_nomatch_a: got %b expected 0", vld); else passed++;
        clear_inputs();
        alu_update_en_i = 1; alu_update_idx_i = 6'd7;
        do_cycle(vld, iss, tag, cnt, rdy);
        total++; if (vld !== 1'b0) $display("FAIL wk_fp_nomatch_b: got %b expected 0", vld); else passed++;
        clear_inputs();
        do_cycle(vld, iss, tag, cnt, rdy);
        total++; if (vld !== 1'b1) $display("FAIL wk_alu_issue: got %b expected 1", vld); else passed++;
        if (iss) begin
            total++;
            if (tag !== exp_q[0]) $display("FAIL wk_tag: got %0d expected %0d", tag, exp_q[0]); else passed++;
            void'(exp_q.pop_front());
        end
        exp_q.delete();
    endtask

    task automatic test_enq_wakeup();
        logic vld, iss, rdy;
        logic [7:0] tag;
        logic [PTR_WTH:0] cnt;
        clear_inputs(); exu_iq__rdy_i = 0;
        dis_iq__vld_i = 1;
        dis_iq__packet_i = mk(8'd30, 6'd5, 0, 1, 6'd12, 1, 0, 6'd13, 1);
        lsu_update_en_i = 1; lsu_update_is_fp_i = 1; lsu_update_idx_i = 6'd12;
        do_cycle(vld, iss, tag, cnt, rdy);
        total++; if (vld !== 1'b0) $display("FAIL enqwk_nobypass: got %b expected 0", vld); else passed++;
        clear_inputs();
        do_cycle(vld, iss, tag, cnt, rdy);
        total++; if (vld !== 1'b1 || tag !== 8'd30) $display("FAIL enqwk_issue: got vld %b tag %0d expected 1 30", vld, tag); else passed++;
        exu_iq__rdy_i = 1;
        do_cycle(vld, iss, tag, cnt, rdy);
        total++; if (iss !== 1'b1 || tag !== 8'd30) $display("FAIL enqwk_deq: got iss %b tag %0d expected 1 30", iss, tag); else passed++;
    endtask

    task automatic test_flush();
        logic vld, iss, rdy;
        logic [7:0] tag, e;
        logic [PTR_WTH:0] cnt;
        clear_inputs(); exu_iq__rdy_i = 0;
        for (int c = 0; c < 3; c++) begin
            dis_iq__vld_i = 1;
            dis_iq__packet_i = mk(8'(40 + c), 6'd1, 0, 1, 6'd1, 0, 1, 6'd1, 1);
            do_cycle(vld, iss, tag, cnt, rdy);
        end
        flush_i = 1; dis_iq__vld_i = 1; exu_iq__rdy_i = 1;
        dis_iq__packet_i = mk(8'd43, 6'd1, 0, 1, 6'd1, 0, 1, 6'd1, 1);
        do_cycle(vld, iss, tag, cnt, rdy);
        total++; if (vld !== 1'b0) $display("FAIL flush_vld_same: got %b expected 0", vld); else passed++;
        clear_inputs();
        do_cycle(vld, iss, tag, cnt, rdy);
        total++; if (cnt !== 3'd0 || vld !== 1'b0 || rdy !== 1'b1)
            $display("FAIL flush_after: got cnt %0d vld %b rdy %b expected 0 0 1", cnt, vld, rdy); else passed++;
        do_cycle(vld, iss, tag, cnt, rdy);
        total++; if (vld !== 1'b0) $display("FAIL flush_dropped: got vld %b tag %0d expected 0", vld, tag); else passed++;
        dis_iq__vld_i = 1;
        dis_iq__packet_i = mk(8'd44, 6'd1, 0, 1, 6'd1, 0, 1, 6'd1, 1);
        exp_q.push_back(8'd44);
        do_cycle(vld, iss, tag, cnt, rdy);
        clear_inputs();
        do_cycle(vld, iss, tag, cnt, rdy);
        total++;
        if (!iss) $display("FAIL flush_reuse: got no issue expected tag 44");
        else begin e = exp_q.pop_front(); if (tag !== e) $display("FAIL flush_reuse: got tag %0d expected %0d", tag, e); else passed++; end
        exp_q.delete();
    endtask

    task automatic test_random_stream();
        logic vld, iss, rdy, acc;
        logic [7:0] tag, e;
        logic [PTR_WTH:0] cnt;
        int m_cnt, sent, got;
        clear_inputs(); m_cnt = 0; sent = 0; got = 0;
        for (int c = 0; c < 200 && got < 10; c++) begin
            dis_iq__vld_i = (sent < 10);
            dis_iq__packet_i = mk(8'(50 + sent), 6'(sent), 0, 1, 6'(sent + 1), 1, 1, 6'd2, 1);
            exu_iq__rdy_i = 1'($urandom_range(0, 1));
            do_cycle(vld, iss, tag, cnt, rdy);
            total++; if (cnt !== 3'(m_cnt)) $display("FAIL rnd_cnt: got %0d expected %0d", cnt, m_cnt); else passed++;
            total++; if (vld !== (m_cnt != 0)) $display("FAIL rnd_vld: got %b expected %b", vld, (m_cnt != 0)); else passed++;
            acc = dis_iq__vld_i && (m_cnt < DEPTH);
            if (iss) begin
                total++; got++;
                if (exp_q.size() == 0) $display("FAIL rnd_order: got tag %0d expected none", tag);
                else begin e = exp_q.pop_front(); if (tag !== e) $display("FAIL rnd_order: got tag %0d expected %0d", tag, e); else passed++; end
            end
            if (acc) begin exp_q.push_back(8'(50 + sent)); sent++; end
            m_cnt = m_cnt + int'(acc) - int'(iss);
        end
        total++; if (got != 10) $display("FAIL rnd_complete: got %0d issued expected 10", got); else passed++;
    endtask

    initial begin
        clear_inputs();
        exu_iq__rdy_i = 0;
        rst_i = 0;
        repeat (2) @(negedge clk);
        rst_i = 1;
        test_reset();
        test_back_to_back();
        test_full();
        test_wakeup();
        test_enq_wakeup();
        test_flush();
        test_random_stream();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
